// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state encoding and operand helper for the iterative
// signed multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int ITERATIONS = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    MULT_ITER,
    DIV_ITER,
    FIXUP,
    DONE,
    DZERO
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shift/accumulate datapath: radix-2 Booth multiply and restoring divide,
// both built around a single 33-bit adder/subtractor.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] m_i,
  input  logic [XLEN-1:0] x_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d, m_q;
  logic            q1_q, q1_d;
  logic [XLEN:0]   add_x, add_y, sum, acc;
  logic            sub;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_x = hi_q;
    add_y = {m_q[XLEN-1], m_q};
    sub   = lo_q[0] & ~q1_q;
    acc   = hi_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    q1_d  = q1_q;
    if (is_div_i) begin
      add_x = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
      add_y = {1'b0, m_q};
      sub   = 1'b1;
    end
    sum = add_x + (sub ? ~add_y : add_y) + {{XLEN{1'b0}}, sub};
    if (is_div_i) begin
      // A negative trial difference means restore: keep the shifted remainder.
      if (sum[XLEN]) begin
        hi_d = add_x;
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end else begin
        hi_d = sum;
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end
    end else begin
      if (lo_q[0] ^ q1_q) acc = sum;
      hi_d = {acc[XLEN], acc[XLEN:1]};
      lo_d = {acc[0], lo_q[XLEN-1:1]};
      q1_d = lo_q[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
      q1_q <= 1'b0;
    end else if (load_i) begin
      hi_q <= '0;
      lo_q <= x_i;
      m_q  <= m_i;
      q1_q <= 1'b0;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      q1_q <= q1_d;
    end
  end

  assign hi_o = hi_q[XLEN-1:0];
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_controller.sv
// Iterative signed MULT/DIV unit: FSM, iteration counter, sign fix-up and
// registered HI/LO write-back.
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] lo_data,
  output logic             hi_we,
  output logic             lo_we
);

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            op_q, sign_a_q, sign_b_q;
  logic            load, step;
  logic [XLEN-1:0] iter_hi, iter_lo, fix_hi, fix_lo;
  logic [XLEN-1:0] res_hi_q, res_lo_q, hi_data_q, lo_data_q;
  logic            done_q, dz_q, we_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load  = 1'b1;
          cnt_d = '0;
          if (op == OP_DIV && op_b == '0) state_d = DZERO;
          else if (op == OP_DIV)          state_d = DIV_ITER;
          else                            state_d = MULT_ITER;
        end
      end
      MULT_ITER, DIV_ITER: begin
        step  = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERATIONS - 1)) state_d = FIXUP;
      end
      FIXUP:       state_d = DONE;
      DONE, DZERO: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Multiply results are already signed; divide works on magnitudes.
  always_comb begin
    fix_hi = iter_hi;
    fix_lo = iter_lo;
    if (op_q == OP_DIV) begin
      if (sign_a_q ^ sign_b_q) fix_lo = -iter_lo;
      if (sign_a_q)            fix_hi = -iter_hi;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      hi_data_q <= '0;
      lo_data_q <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q     <= op;
        sign_a_q <= op_a[WIDTH-1];
        sign_b_q <= op_b[WIDTH-1];
      end
      if (state_q == FIXUP) begin
        res_hi_q <= fix_hi;
        res_lo_q <= fix_lo;
      end
      // Status pulses are registered from the state, one cycle behind it.
      done_q <= (state_q == DONE);
      we_q   <= (state_q == DONE);
      dz_q   <= (state_q == DZERO);
      if (state_q == DONE) begin
        hi_data_q <= res_hi_q;
        lo_data_q <= res_lo_q;
      end
    end
  end

  muldiv_iter u_iter (
    .clock   (clock),
    .reset   (reset),
    .load_i  (load),
    .step_i  (step),
    .is_div_i(op_q),
    .m_i     ((op == OP_DIV) ? magnitude(op_b) : op_b),
    .x_i     ((op == OP_DIV) ? magnitude(op_a) : op_a),
    .hi_o    (iter_hi),
    .lo_o    (iter_lo)
  );

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi_we    = we_q;
  assign lo_we    = we_q;
  assign hi_data  = hi_data_q;
  assign lo_data  = lo_data_q;

endmodule

// File: doc/muldiv_controller.md
MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  in  1  0 = MULT (signed), 1 = DIV (signed); sampled with start.
REQ-006 SHALL have port op_a  in  32  multiplicand / dividend (RegA); sampled with start.
REQ-007 SHALL have port op_b  in  32  multiplier / divisor (RegB); sampled with start.
REQ-008 SHALL have port busy  out  1  high while an operation is in progress; the control unit stalls on it.
REQ-009 SHALL have port done  out  1  one-cycle pulse marking operation completion.
REQ-010 SHALL have port div_zero  out  1  one-cycle pulse in place of done when a DIV has op_b == 0.
REQ-011 SHALL have ports hi_data and lo_data  out  32 each  results presented to the HI and LO registers.
REQ-012 SHALL have ports hi_we and lo_we  out  1 each  write enables for the HI and LO registers.

Function
REQ-013 SHALL implement the FSM states IDLE, MULT_ITER, DIV_ITER, FIXUP, DONE and DZERO.
REQ-014 IDLE with start=1 SHALL latch op, op_a and op_b, clear the 5-bit iteration counter, and go to MULT_ITER or DIV_ITER.
REQ-015 IDLE with start=1, op=DIV and op_b==0 SHALL go to DZERO.
REQ-016 MULT_ITER SHALL perform one radix-2 Booth step per cycle for exactly 32 cycles, then go to FIXUP.
REQ-017 DIV_ITER SHALL perform one restoring step per cycle on magnitudes |op_a| and |op_b| for exactly 32 cycles, then go to FIXUP.
REQ-018 FIXUP SHALL apply signs in one cycle, then go to DONE.
  - MULT: no sign change.
  - DIV quotient: negated if the operand signs differ.
  - DIV remainder: takes the sign of the dividend.
REQ-019 DONE SHALL last exactly one cycle, with done=hi_we=lo_we=1, then return to IDLE.
  - MULT: hi_data = product[63:32], lo_data = product[31:0].
  - DIV: lo_data = quotient, hi_data = remainder.
REQ-020 DZERO SHALL last exactly one cycle, with div_zero=1, done=0, hi_we=lo_we=0, then return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle following the 34th rising edge after the edge that sampled start; div_zero SHALL be high in the cycle following the first edge after start.
REQ-022 busy SHALL be 1 in every state except IDLE, including DONE and DZERO.
REQ-023 start asserted while busy=1 SHALL be ignored, and SHALL NOT be queued.
REQ-024 Changes on op_a, op_b or op after the sampling edge SHALL NOT affect the result.
REQ-025 0x80000000 / 0xFFFFFFFF SHALL yield lo_data=0x80000000 and hi_data=0 with done (no exception).
REQ-026 hi_data and lo_data SHALL hold their last DONE values until the next DONE; they are valid only when hi_we/lo_we=1.
REQ-027 hi_we, lo_we, done and div_zero SHALL be registered outputs.

Reset
REQ-028 On reset the block SHALL immediately go to IDLE, with counter=0, busy=0, done=0, div_zero=0, hi_we=0, lo_we=0, hi_data=0, lo_data=0 and all internal operand/accumulator registers 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no write pulse, either during reset or after release.
REQ-030 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-031 Package muldiv_pkg SHALL hold the op encoding constants (OP_MULT=0, OP_DIV=1), the FSM state enum and the constant ITERATIONS=32.
REQ-032 Sub-module muldiv_iter SHALL hold the shift/accumulate registers and the 33-bit adder/subtractor; the FSM, counter and sign fix-up stay in muldiv_controller.

Verification
REQ-033 MULT 3 x 0xFFFFFFFC (-4) -> done at the required latency with hi_data=0xFFFFFFFF, lo_data=0xFFFFFFF4, hi_we=lo_we=1 for one cycle.
REQ-034 MULT 0x80000000 x 0x80000000 -> hi_data=0x40000000, lo_data=0x00000000.
REQ-035 DIV 7 / 0xFFFFFFFE (-2) -> lo_data=0xFFFFFFFD, hi_data=0x00000001; DIV 0xFFFFFFF9 (-7) / 2 -> lo_data=0xFFFFFFFD, hi_data=0xFFFFFFFF.
REQ-036 DIV 5 / 0 -> div_zero pulse one cycle after start, with no done, no write enables and HI/LO outputs unchanged.
REQ-037 Reset pulse at iteration 10 of a MULT -> busy=0 immediately and no hi_we during the next 40 cycles; a following start of DIV 0x80000000/0xFFFFFFFF -> lo_data=0x80000000, hi_data=0.
REQ-038 start re-asserted every cycle during a MULT -> exactly one done pulse; a new operation begins only from IDLE.
